// File: rtl/obi_error_responder.sv
// OBI slave answering crossbar decode misses: grants every request, returns an error response
// with a poison read value, logs the first faulting access plus a saturating miss count.
module obi_error_responder #(
  parameter logic [31:0] RESP_DATA = 32'hBADACCE5,
  parameter int          LATENCY   = 1,
  parameter int          DEPTH     = 2,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  input  logic             clear_i,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [31:0]      err_addr_o,
  output logic             err_we_o,
  output logic             irq_o
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] DEPTH_L = IW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {EMPTY = 1'b0, LOGGED = 1'b1} log_state_t;

  logic [IW-1:0]    inflight;
  logic [IW-1:0]    fifo_cnt;
  logic [IW-1:0]    cnt_after_pop;
  logic [IW-1:0]    fifo_cnt_nxt;
  logic [DEPTH-1:0] fifo_we;
  logic [DEPTH-1:0] fifo_shifted;
  logic [DEPTH-1:0] fifo_we_nxt;
  logic             push_v;
  logic             push_we;
  logic             pop;
  log_state_t       log_state;
  logic             unused_inputs;

  // Payload is never stored; only the we tag decides the response data.
  assign unused_inputs = ^{be_i, wdata_i};

  assign gnt_o    = rst_ni & req_i & (inflight < DEPTH_L);
  assign rvalid_o = (fifo_cnt != {IW{1'b0}});
  assign pop      = rvalid_o & rready_i;
  assign err_o    = rvalid_o;
  assign rdata_o  = (rvalid_o && !fifo_we[0]) ? RESP_DATA : 32'h0000_0000;
  assign irq_o    = (log_state == LOGGED);

  // With LATENCY==1 a granted tag goes straight into the FIFO on the grant edge.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_v  = gnt_o;
      assign push_we = we_i;
    end else begin : g_pipe
      logic [LATENCY-2:0] pipe_v;
      logic [LATENCY-2:0] pipe_we;

      // Latency shift pipe carrying {valid, we} tags toward the FIFO
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          pipe_v  <= {(LATENCY-1){1'b0}};
          pipe_we <= {(LATENCY-1){1'b0}};
        end else begin
          pipe_v[0]  <= gnt_o;
          pipe_we[0] <= we_i;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_we[i] <= pipe_we[i-1];
          end
        end
      end

      assign push_v  = pipe_v[LATENCY-2];
      assign push_we = pipe_we[LATENCY-2];
    end
  endgenerate

  // In-flight accounting: grant adds, pop removes
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight <= {IW{1'b0}};
    end else if (gnt_o && !pop) begin
      inflight <= inflight + IW'(1);
    end else if (!gnt_o && pop) begin
      inflight <= inflight - IW'(1);
    end else begin
      inflight <= inflight;
    end
  end

  // Shift-down FIFO next state: head at index 0, push lands after surviving entries
  always_comb begin
    fifo_shifted  = pop ? (fifo_we >> 1) : fifo_we;
    cnt_after_pop = pop ? (fifo_cnt - IW'(1)) : fifo_cnt;
    fifo_we_nxt   = fifo_shifted;
    for (int i = 0; i < DEPTH; i++) begin
      fifo_we_nxt[i] = (push_v && (cnt_after_pop == IW'(i))) ? push_we : fifo_shifted[i];
    end
    fifo_cnt_nxt = push_v ? (cnt_after_pop + IW'(1)) : cnt_after_pop;
  end

  // Response FIFO state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo_cnt <= {IW{1'b0}};
      fifo_we  <= {DEPTH{1'b0}};
    end else begin
      fifo_cnt <= fifo_cnt_nxt;
      fifo_we  <= fifo_we_nxt;
    end
  end

  // Fault log: a clear coinciding with a grant is applied first, so the grant re-logs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      log_state  <= EMPTY;
      err_cnt_o  <= {CNT_W{1'b0}};
      err_addr_o <= 32'h0000_0000;
      err_we_o   <= 1'b0;
    end else begin
      case (log_state)
        EMPTY: begin
          if (gnt_o) begin
            log_state  <= LOGGED;
            err_cnt_o  <= CNT_W'(1);
            err_addr_o <= addr_i;
            err_we_o   <= we_i;
          end else begin
            log_state <= EMPTY;
          end
        end
        LOGGED: begin
          if (gnt_o && clear_i) begin
            log_state  <= LOGGED;
            err_cnt_o  <= CNT_W'(1);
            err_addr_o <= addr_i;
            err_we_o   <= we_i;
          end else if (gnt_o) begin
            log_state <= LOGGED;
            err_cnt_o <= (err_cnt_o == CNT_MAX) ? CNT_MAX : (err_cnt_o + CNT_W'(1));
          end else if (clear_i) begin
            log_state  <= EMPTY;
            err_cnt_o  <= {CNT_W{1'b0}};
            err_addr_o <= 32'h0000_0000;
            err_we_o   <= 1'b0;
          end else begin
            log_state <= LOGGED;
          end
        end
        default: begin
          log_state  <= EMPTY;
          err_cnt_o  <= {CNT_W{1'b0}};
          err_addr_o <= 32'h0000_0000;
          err_we_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_error_responder.sv
// Directed bench for obi_error_responder: per-cycle vector table plus multi-cycle sequences
// for back-pressure, counter saturation and reset with responses in flight.
module tb_obi_error_responder;

  localparam logic [31:0] BAD = 32'hBADACCE5;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req, we, rready, clear;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt, rvalid, err, err_we, irq;
  logic [31:0] rdata, err_addr;
  logic [15:0] err_cnt;
  logic        s_gnt, s_rvalid, s_err, s_err_we, s_irq;
  logic [31:0] s_rdata, s_err_addr;
  logic [1:0]  s_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  obi_error_responder dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
    .err_o(err), .clear_i(clear), .err_cnt_o(err_cnt), .err_addr_o(err_addr),
    .err_we_o(err_we), .irq_o(irq)
  );

  obi_error_responder #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(s_gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(s_rvalid), .rready_i(rready), .rdata_o(s_rdata),
    .err_o(s_err), .clear_i(clear), .err_cnt_o(s_err_cnt), .err_addr_o(s_err_addr),
    .err_we_o(s_err_we), .irq_o(s_irq)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic        rready;
    logic        clear;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        irq;
    logic [15:0] cnt;
    logic [31:0] eaddr;
    logic        ewe;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic w, input logic rr,
                              input logic c, input logic g, input logic rv, input logic [31:0] rd,
                              input logic i, input logic [15:0] n, input logic [31:0] ea,
                              input logic ew);
    vec_t v;
    v.req = r; v.addr = a; v.we = w; v.rready = rr; v.clear = c;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.irq = i; v.cnt = n; v.eaddr = ea; v.ewe = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; req = 1'b0; rready = 1'b0; clear = 1'b0; we = 1'b0; addr = 32'h0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic rr);
    @(negedge clk);
    req = r; addr = a; we = w; rready = rr; clear = 1'b0;
    #1;
  endtask

  initial begin
    // inputs -> pre-edge expectations {gnt, rvalid, rdata, irq, cnt, err_addr, err_we}
    vecs[0]  = mk(1'b1, 32'h9000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0, 32'h0, 1'b0);
    vecs[1]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BAD, 1'b1, 16'd1, 32'h9000_0000, 1'b0);
    vecs[2]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 16'd1, 32'h9000_0000, 1'b0);
    vecs[3]  = mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0, 32'h0, 1'b0);
    vecs[4]  = mk(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 16'd1, 32'h0, 1'b1);
    vecs[5]  = mk(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 16'd2, 32'h0, 1'b1);
    vecs[6]  = mk(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 16'd2, 32'h0, 1'b1);
    vecs[7]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BAD, 1'b1, 16'd2, 32'h0, 1'b1);
    vecs[8]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 16'd2, 32'h0, 1'b1);
    vecs[9]  = mk(1'b1, 32'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 16'd2, 32'h0, 1'b1);
    vecs[10] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BAD, 1'b1, 16'd1, 32'h1234, 1'b0);
    vecs[11] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 16'd1, 32'h1234, 1'b0);
    vecs[12] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 32'h0, 1'b0);

    rst_ni = 1'b0; req = 1'b0; we = 1'b0; rready = 1'b0; clear = 1'b0;
    addr = 32'h0; be = 4'hF; wdata = 32'hDEAD_BEEF;
    do_reset();
    #1;
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_cnt", {16'h0, err_cnt}, 32'h0);
    check("reset_addr", err_addr, 32'h0);
    check("reset_we", {31'h0, err_we}, 32'h0);

    // Cycle-by-cycle table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req = vecs[i].req; addr = vecs[i].addr; we = vecs[i].we;
      rready = vecs[i].rready; clear = vecs[i].clear;
      #1;
      check($sformatf("v%0d_gnt", i), {31'h0, gnt}, {31'h0, vecs[i].gnt});
      check($sformatf("v%0d_rvalid", i), {31'h0, rvalid}, {31'h0, vecs[i].rvalid});
      check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].rvalid});
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      check($sformatf("v%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].irq});
      check($sformatf("v%0d_cnt", i), {16'h0, err_cnt}, {16'h0, vecs[i].cnt});
      check($sformatf("v%0d_eaddr", i), err_addr, vecs[i].eaddr);
      check($sformatf("v%0d_ewe", i), {31'h0, err_we}, {31'h0, vecs[i].ewe});
    end

    // Back-pressure: fill with read then write, stall 5 cycles, then grant alongside a pop
    do_reset();
    drive(1'b1, 32'hA0, 1'b0, 1'b0);
    check("bp_gnt0", {31'h0, gnt}, 32'h1);
    drive(1'b1, 32'hA4, 1'b1, 1'b0);
    check("bp_gnt1", {31'h0, gnt}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'hA8, 1'b0, 1'b0);
      check($sformatf("bp_stall%0d_gnt", k), {31'h0, gnt}, 32'h0);
      check($sformatf("bp_stall%0d_rvalid", k), {31'h0, rvalid}, 32'h1);
      check($sformatf("bp_stall%0d_rdata", k), rdata, BAD);
    end
    drive(1'b1, 32'hA8, 1'b0, 1'b1);
    check("bp_pop_nogrant", {31'h0, gnt}, 32'h0);
    check("bp_head_read", rdata, BAD);
    drive(1'b1, 32'hAC, 1'b0, 1'b1);
    check("bp_grant_pop_gnt", {31'h0, gnt}, 32'h1);
    check("bp_head_write", rdata, 32'h0);
    drive(1'b1, 32'hB0, 1'b0, 1'b0);
    check("bp_refill_gnt", {31'h0, gnt}, 32'h1);
    check("bp_refill_rdata", rdata, BAD);
    drive(1'b1, 32'hB4, 1'b0, 1'b0);
    check("bp_full_gnt", {31'h0, gnt}, 32'h0);
    check("bp_cnt", {16'h0, err_cnt}, 32'd4);

    // Saturation: CNT_W=2 instance counts 1,2,3,3,3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h100 + 32'(k * 4), 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_cnt", k), {30'h0, s_err_cnt}, (k < 3) ? 32'(k + 1) : 32'd3);
      check($sformatf("wide%0d_cnt", k), {16'h0, err_cnt}, 32'(k + 1));
    end
    check("sat_first_addr", s_err_addr, 32'h100);

    // Reset with two responses in flight
    do_reset();
    drive(1'b1, 32'hC0, 1'b0, 1'b0);
    drive(1'b1, 32'hC4, 1'b1, 1'b0);
    @(negedge clk);
    rst_ni = 1'b0; req = 1'b1; rready = 1'b1;
    #1;
    check("rst_gnt", {31'h0, gnt}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_cnt", {16'h0, err_cnt}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1; req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_rvalid", k), {31'h0, rvalid}, 32'h0);
    end
    drive(1'b1, 32'hD0, 1'b0, 1'b1);
    check("post_rst_gnt", {31'h0, gnt}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("post_rst_resp", rdata, BAD);
    check("post_rst_eaddr", err_addr, 32'hD0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
